// File: rtl/image_loader.sv
// image_loader: receives a block of bytes from a UART into DRAM, enables the
// processor until it reports completion, then streams a DRAM window back out
// through the UART transmitter.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; lengths and dump base latched on start
// LD_WAIT | waiting for rx_ready
// LD_WR | one-cycle DRAM write of the received byte, rx acknowledge
// RUN   | proc_run high until proc_done
// DP_RD | DRAM address = dump_base + cnt presented
// DP_TX | waiting for tx_busy low, then strobe the read byte out
// DP_GAP | GAP idle cycles so the transmitter can raise tx_busy
// DONE  | done high; start restarts the sequence
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start, load_len             sequence start, bytes to receive
//   dump_base, dump_len         first byte / byte count to send back
//   rx_data, rx_ready, rx_ready_clr   UART receive side
//   tx_busy, tx_data, tx_wr_en        UART transmit side
//   mem_addr, mem_we, mem_wdata, mem_rdata   DRAM (1-cycle read latency)
//   proc_run, proc_done         processor handshake
//   done, state                 completion flag, FSM encoding
module image_loader #(
  parameter int ADDR_W = 17,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] load_len,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W-1:0] dump_len,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic              rx_ready_clr,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              proc_run,
  input  logic              proc_done,
  output logic              done,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_WAIT = 3'd1,
    LD_WR   = 3'd2,
    RUN     = 3'd3,
    DP_RD   = 3'd4,
    DP_TX   = 3'd5,
    DP_GAP  = 3'd6,
    DONE    = 3'd7
  } state_t;

  localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
  // A GAP of 0 still spends one cycle in DP_GAP.
  localparam int GAP_LD = (GAP > 0) ? GAP - 1 : 0;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] load_len_q, load_len_d;
  logic [ADDR_W-1:0] dump_base_q, dump_base_d;
  logic [ADDR_W-1:0] dump_len_q, dump_len_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_wr_en_q, tx_wr_en_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              wr_q, wr_d;
  logic              proc_run_q, proc_run_d;
  logic              done_q, done_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_len_d  = load_len_q;
    dump_base_d = dump_base_q;
    dump_len_d  = dump_len_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tx_data_d   = tx_data_q;
    tx_wr_en_d  = 1'b0;
    gap_d       = gap_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load_len_d  = load_len;
          dump_base_d = dump_base;
          dump_len_d  = dump_len;
          cnt_d       = '0;
          state_d     = (load_len == '0) ? RUN : LD_WAIT;
        end
      end
      LD_WAIT: begin
        if (rx_ready) begin
          mem_wdata_d = rx_data;
          mem_addr_d  = cnt_q;
          state_d     = LD_WR;
        end
      end
      LD_WR: begin
        cnt_d   = cnt_q + ADDR_W'(1);
        // Compare before the increment so a full-range length never wraps cnt.
        state_d = (cnt_q == load_len_q - ADDR_W'(1)) ? RUN : LD_WAIT;
      end
      RUN: begin
        if (proc_done) begin
          cnt_d = '0;
          if (dump_len_q == '0) begin
            state_d = DONE;
          end else begin
            mem_addr_d = dump_base_q;
            state_d    = DP_RD;
          end
        end
      end
      DP_RD: begin
        state_d = DP_TX;
      end
      DP_TX: begin
        if (!tx_busy) begin
          tx_data_d  = mem_rdata;
          tx_wr_en_d = 1'b1;
          cnt_d      = cnt_q + ADDR_W'(1);
          gap_d      = GAP_W'(GAP_LD);
          state_d    = DP_GAP;
        end
      end
      DP_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_W'(1);
        end else if (cnt_q == dump_len_q) begin
          state_d = DONE;
        end else begin
          // Address sum is allowed to wrap past the top of DRAM.
          mem_addr_d = dump_base_q + cnt_q;
          state_d    = DP_RD;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_d       = (state_d == LD_WR);
    proc_run_d = (state_d == RUN);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      load_len_q  <= '0;
      dump_base_q <= '0;
      dump_len_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tx_data_q   <= '0;
      tx_wr_en_q  <= 1'b0;
      gap_q       <= '0;
      wr_q        <= 1'b0;
      proc_run_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_len_q  <= load_len_d;
      dump_base_q <= dump_base_d;
      dump_len_q  <= dump_len_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tx_data_q   <= tx_data_d;
      tx_wr_en_q  <= tx_wr_en_d;
      gap_q       <= gap_d;
      wr_q        <= wr_d;
      proc_run_q  <= proc_run_d;
      done_q      <= done_d;
    end
  end

  assign state        = state_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_we       = wr_q;
  assign rx_ready_clr = wr_q;
  assign tx_data      = tx_data_q;
  assign tx_wr_en     = tx_wr_en_q;
  assign proc_run     = proc_run_q;
  assign done         = done_q;

endmodule

// File: tb/tb_image_loader.sv
module tb_image_loader;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] load_len = '0, dump_base = '0, dump_len = '0;
  logic [7:0]    rx_data = '0;
  logic          rx_ready = 1'b0;
  logic          rx_ready_clr;
  logic          tx_busy = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_wr_en;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          proc_run;
  logic          proc_done = 1'b0;
  logic          done;
  logic [2:0]    state;

  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [7:0]    pl_data = '0;
  logic [7:0]    mem [0:(1<<AW)-1];

  int checks = 0, failures = 0;
  int we_cnt = 0, clr_cnt = 0, tx_cnt = 0;
  logic [AW-1:0] wr_addr_q[$], rd_addr_q[$];
  logic [7:0]    wr_data_q[$], tx_q[$];

  image_loader #(.ADDR_W(AW), .GAP(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_len(load_len),
    .dump_base(dump_base), .dump_len(dump_len), .rx_data(rx_data),
    .rx_ready(rx_ready), .rx_ready_clr(rx_ready_clr), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_wr_en(tx_wr_en), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .proc_run(proc_run), .proc_done(proc_done), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  // DRAM model: synchronous write, one-cycle read latency.
  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors and per-cycle output invariants.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("we_vs_state", {31'd0, mem_we}, {31'd0, state == 3'd2});
      chk("clr_vs_state", {31'd0, rx_ready_clr}, {31'd0, state == 3'd2});
      chk("run_vs_state", {31'd0, proc_run}, {31'd0, state == 3'd3});
      chk("done_vs_state", {31'd0, done}, {31'd0, state == 3'd7});
      if (rx_ready_clr) clr_cnt++;
      if (mem_we) begin
        we_cnt++;
        if (wr_addr_q.size() == 0) chk("wr_extra", 32'd1, 32'd0);
        else begin
          chk("wr_addr", 32'(mem_addr), 32'(wr_addr_q.pop_front()));
          chk("wr_data", 32'(mem_wdata), 32'(wr_data_q.pop_front()));
        end
      end
      if (state == 3'd4) begin
        if (rd_addr_q.size() == 0) chk("rd_extra", 32'd1, 32'd0);
        else chk("rd_addr", 32'(mem_addr), 32'(rd_addr_q.pop_front()));
      end
      if (tx_wr_en) begin
        tx_cnt++;
        if (tx_q.size() == 0) chk("tx_extra", 32'd1, 32'd0);
        else chk("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
      end
    end
  end

  task automatic wait_state(input logic [2:0] s, input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc && state !== s; i++) @(negedge clk);
    chk(tag, 32'(state), 32'(s));
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk); proc_done = 1'b1;
    @(negedge clk); proc_done = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat (3) @(negedge clk);
    rx_data = b; rx_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rx_ready_clr) break;
    end
    chk("rx_ack", {31'd0, rx_ready_clr}, 32'd1);
    @(posedge clk); #1 rx_ready = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk); pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk); pl_we = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_outs"}, {27'd0, mem_we, rx_ready_clr, tx_wr_en, proc_run, done}, 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_data"}, {16'd0, mem_wdata, tx_data}, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    preload(17'h1FFFE, 8'hA1);
    preload(17'h1FFFF, 8'hB2);
    preload(17'h00000, 8'hEE);
    @(negedge clk); rst_n = 1'b1;

    // Load four bytes with gaps between rx_ready assertions.
    load_len = 17'd4; dump_base = 17'h1FFFE; dump_len = 17'd3;
    wr_addr_q = '{17'd0, 17'd1, 17'd2, 17'd3};
    wr_data_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    pulse_start();
    load_len = 17'd9; dump_len = 17'd1;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_state(3'd3, 50, "to_run");
    chk("run_proc_run", {31'd0, proc_run}, 32'd1);
    chk("load_we_cnt", 32'(we_cnt), 32'd4);
    chk("load_clr_cnt", 32'(clr_cnt), 32'd4);

    // start during RUN must be ignored.
    load_len = 17'd7;
    pulse_start();
    repeat (3) @(negedge clk);
    chk("run_ignores_start", 32'(state), 32'd3);

    // Dump with address wrap; transmitter busy for 50 cycles first.
    rd_addr_q = '{17'h1FFFE, 17'h1FFFF, 17'h00000};
    tx_q = '{8'hA1, 8'hB2, 8'h11};
    tx_busy = 1'b1;
    pulse_done();
    wait_state(3'd5, 20, "to_dp_tx");
    repeat (50) @(negedge clk);
    chk("busy_no_tx", 32'(tx_cnt), 32'd0);
    chk("busy_hold_state", 32'(state), 32'd5);
    tx_busy = 1'b0;
    for (int i = 0; i < 20 && tx_cnt == 0; i++) @(negedge clk);
    chk("first_tx", 32'(tx_cnt), 32'd1);
    pulse_start();
    wait_state(3'd7, 100, "to_done");
    chk("dump_tx_cnt", 32'(tx_cnt), 32'd3);
    chk("done_flag", {31'd0, done}, 32'd1);
    chk("rd_left", 32'(rd_addr_q.size()), 32'd0);

    // Restart from DONE with zero lengths: IDLE path straight to RUN then DONE.
    load_len = '0; dump_len = '0; dump_base = 17'h00010;
    pulse_start();
    chk("zero_run", 32'(state), 32'd3);
    repeat (4) @(negedge clk);
    chk("zero_still_run", 32'(state), 32'd3);
    pulse_done();
    chk("zero_done", 32'(state), 32'd7);
    chk("zero_we", 32'(we_cnt), 32'd4);
    chk("zero_tx", 32'(tx_cnt), 32'd3);

    // Reset after two of four bytes, with a third byte pending.
    load_len = 17'd4; dump_len = 17'd2;
    wr_addr_q = '{17'd0, 17'd1};
    wr_data_q = '{8'h55, 8'h66};
    pulse_start();
    send_byte(8'h55); send_byte(8'h66);
    @(negedge clk);
    #1 rst_n = 1'b0; rx_data = 8'h77; rx_ready = 1'b1;
    #1 chk_reset_outputs("midload_rst");
    repeat (3) @(negedge clk);
    chk("rst_no_write", 32'(we_cnt), 32'd6);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", 32'(state), 32'd0);
    chk("rx_unacked", 32'(clr_cnt), 32'd6);
    rx_ready = 1'b0;

    // Restart with two bytes: writes start again at address 0.
    load_len = 17'd2; dump_len = '0;
    wr_addr_q = '{17'd0, 17'd1};
    wr_data_q = '{8'h88, 8'h99};
    pulse_start();
    send_byte(8'h88); send_byte(8'h99);
    wait_state(3'd3, 50, "restart_run");
    chk("restart_we_cnt", 32'(we_cnt), 32'd8);
    pulse_done();
    wait_state(3'd7, 10, "restart_done");
    chk("wr_left", 32'(wr_addr_q.size()), 32'd0);
    chk("tx_left", 32'(tx_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, DRAM byte-address width.
REQ-002 SHALL have parameter GAP, default 2, idle cycles after each tx_wr_en pulse before tx_busy is sampled.
REQ-003 SHALL have port clk  in  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports start in 1 (begin load/run/dump sequence) and load_len in ADDR_W (bytes to receive); both are sampled in IDLE.
REQ-006 SHALL have ports dump_base in ADDR_W (first byte to return) and dump_len in ADDR_W (bytes to return); both are sampled in IDLE.
REQ-007 SHALL have ports rx_data in 8 (UART received byte), rx_ready in 1 (byte valid, level) and rx_ready_clr out 1 (one-cycle acknowledge).
REQ-008 SHALL have ports tx_busy in 1 (UART transmitter busy), tx_data out 8 (byte to send) and tx_wr_en out 1 (one-cycle send strobe).
REQ-009 SHALL have DRAM ports mem_addr out ADDR_W, mem_we out 1, mem_wdata out 8 and mem_rdata in 8; read data is valid one cycle after mem_addr is presented.
REQ-010 SHALL have ports proc_run out 1 (processor enable) and proc_done in 1 (processor finished, level or pulse).
REQ-011 SHALL have ports done out 1 (sequence complete) and state out 3 (current FSM encoding, debug).

Function
REQ-012 SHALL implement FSM states IDLE=0, LD_WAIT=1, LD_WR=2, RUN=3, DP_RD=4, DP_TX=5, DP_GAP=6, DONE=7; state SHALL equal this encoding.
REQ-013 IDLE: on start=1, SHALL latch load_len, dump_base and dump_len, clear the byte counter cnt, and go to LD_WAIT (RUN if load_len=0).
REQ-014 LD_WAIT: when rx_ready=1, SHALL register rx_data into mem_wdata and go to LD_WR.
REQ-015 LD_WR: SHALL assert mem_we=1 and rx_ready_clr=1 for exactly this cycle with mem_addr=cnt, then increment cnt.
REQ-016 After LD_WR, SHALL go to RUN when the pre-increment cnt=load_len-1, else back to LD_WAIT; each received byte produces exactly one write.
REQ-017 RUN: SHALL hold proc_run=1 and mem_we=0; on proc_done=1 SHALL clear cnt and go to DP_RD (DONE if dump_len=0).
REQ-018 proc_run SHALL be a registered output, high only in RUN.
REQ-019 DP_RD: SHALL drive mem_addr=dump_base+cnt, truncated modulo 2^ADDR_W (wrap-around permitted), then go to DP_TX.
REQ-020 DP_TX: SHALL wait until tx_busy=0, then set tx_data=mem_rdata, pulse tx_wr_en=1 for one cycle, increment cnt and go to DP_GAP.
REQ-021 tx_data SHALL hold its value until the next tx_wr_en pulse.
REQ-022 DP_GAP: SHALL wait GAP cycles, then go to DONE if cnt=dump_len, else to DP_RD.
REQ-023 DONE: SHALL hold done=1; on start=1 SHALL behave as in IDLE (restart with freshly latched lengths).
REQ-024 start SHALL be ignored in all states other than IDLE and DONE; changes to length inputs after latching SHALL have no effect.
REQ-025 rx_ready in any state other than LD_WAIT SHALL be left unacknowledged (byte retained by UART); rx_ready_clr SHALL be 0 outside LD_WR.
REQ-026 mem_we SHALL be 0 outside LD_WR; tx_wr_en SHALL be 0 outside the DP_TX exit cycle.
REQ-027 cnt SHALL be ADDR_W bits wide; load_len or dump_len of 2^ADDR_W-1 SHALL complete without overflow.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, cnt=0, all latched lengths=0, mem_addr=0, mem_wdata=0, tx_data=0, and mem_we, rx_ready_clr, tx_wr_en, proc_run and done to 0.
REQ-029 Reset asserted mid-load or mid-dump SHALL abort immediately with no further write or strobe; after release, the block SHALL wait in IDLE for start.

Verification
REQ-030 Bench SHALL cover: load_len=4, bytes 0x11,0x22,0x33,0x44 with rx_ready gaps -> exactly 4 mem_we pulses at addr 0..3 with matching data, 4 rx_ready_clr pulses, then proc_run=1.
REQ-031 Bench SHALL cover: proc_done pulse, dump_base=0x1FFFE, dump_len=3 -> reads at addr 0x1FFFE, 0x1FFFF, 0x00000 and 3 tx_wr_en pulses carrying the DRAM contents in order, then done=1.
REQ-032 Bench SHALL cover: tx_busy held high 50 cycles during DP_TX -> no tx_wr_en until tx_busy falls, then exactly one pulse.
REQ-033 Bench SHALL cover: load_len=0 and dump_len=0 -> IDLE -> RUN -> DONE, with zero mem_we and zero tx_wr_en.
REQ-034 Bench SHALL cover: rst_n low after 2 of 4 loaded bytes -> all outputs 0 in the same cycle, state=0; restart with load_len=2 -> writes begin again at addr 0.
REQ-035 Bench SHALL cover: start pulsed during RUN and dump -> no effect; start in DONE -> new sequence begins with newly latched lengths.
